vec_alu: RTL

Parametrised lane-wise vector ALU engine that replaces the fixed 64-bit adder between the MMU read streams and the MMU write stream. It buffers the independent A and B operand streams, pairs their beats, and applies a runtime-selected lane-wise operation (add, sub, min, max) over `ELEM_BITS`-wide lanes. It returns results on a valid/ready stream with backpressure, counts `length` beats per launch and pulses `done` when the last result has been consumed.

---
 rtl/vec_alu_pkg.sv | 22 ++
 rtl/vec_alu_fifo.sv | 53 +++++
 rtl/vec_alu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vec_alu_pkg.sv
// rtl/vec_alu_pkg.sv - shared types and lane-count helper for the vector ALU
package vec_alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MIN = 2'd2,
        MAX = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int lane_count(input int data_bits, input int elem_bits);
        return data_bits / elem_bits;
    endfunction

endpackage

// File: rtl/vec_alu_fifo.sv
// rtl/vec_alu_fifo.sv - synchronous operand FIFO with registered occupancy count
module vec_alu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Storage array: data only, pointers decide validity so no reset needed
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vec_alu.sv
// rtl/vec_alu.sv - lane-wise vector ALU engine; define VEC_ALU_SAT_EN for saturating add/sub
module vec_alu
    import vec_alu_pkg::*;
#(
    parameter int DATA_BITS  = 64,
    parameter int ELEM_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_BITS   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [LEN_BITS-1:0]  length,
    output logic                 busy,
    output logic                 done,
    input  logic                 a_valid,
    input  logic [DATA_BITS-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [DATA_BITS-1:0] b_data,
    output logic                 b_ready,
    output logic                 c_valid,
    output logic [DATA_BITS-1:0] c_data,
    input  logic                 c_ready,
    output logic                 sat_flag
);
    localparam int LANES = lane_count(DATA_BITS, ELEM_BITS);

    state_t                state_q, state_d;
    op_t                   op_q;
    logic [LEN_BITS-1:0]   len_q, a_cnt_q, b_cnt_q, issue_cnt_q;
    logic                  out_valid_q, sat_q;
    logic [DATA_BITS-1:0]  out_data_q;
    logic                  a_full, a_empty, b_full, b_empty;
    logic                  a_push, b_push, pop, last_pop;
    logic [DATA_BITS-1:0]  a_head, b_head, result;
    logic [LANES-1:0]      lane_sat;

    assign a_ready  = (state_q == RUN) && !a_full && (a_cnt_q < len_q);
    assign b_ready  = (state_q == RUN) && !b_full && (b_cnt_q < len_q);
    assign a_push   = a_valid && a_ready;
    assign b_push   = b_valid && b_ready;
    assign pop      = (state_q == RUN) && !a_empty && !b_empty && (!out_valid_q || c_ready);
    assign last_pop = pop && ((issue_cnt_q + LEN_BITS'(1)) == len_q);

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign c_valid  = out_valid_q;
    assign c_data   = out_data_q;
    assign sat_flag = sat_q;

    vec_alu_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clock(clock), .reset_n(reset_n),
        .push_i(a_push), .push_data_i(a_data), .pop_i(pop),
        .pop_data_o(a_head), .full_o(a_full), .empty_o(a_empty)
    );

    vec_alu_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clock(clock), .reset_n(reset_n),
        .push_i(b_push), .push_data_i(b_data), .pop_i(pop),
        .pop_data_o(b_head), .full_o(b_full), .empty_o(b_empty)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [ELEM_BITS-1:0] la, lb, add_l, sub_l, res_l;
        logic [ELEM_BITS:0]   diff;
        logic                 add_sat, sub_sat, sat_l;

        assign la   = a_head[g*ELEM_BITS +: ELEM_BITS];
        assign lb   = b_head[g*ELEM_BITS +: ELEM_BITS];
        // The borrow bit doubles as the unsigned a<b compare for MIN/MAX
        assign diff = {1'b0, la} - {1'b0, lb};

`ifdef VEC_ALU_SAT_EN
        logic [ELEM_BITS:0] sum;
        assign sum     = {1'b0, la} + {1'b0, lb};
        assign add_sat = sum[ELEM_BITS];
        assign add_l   = add_sat ? '1 : sum[ELEM_BITS-1:0];
        assign sub_sat = diff[ELEM_BITS];
        assign sub_l   = sub_sat ? '0 : diff[ELEM_BITS-1:0];
`else
        assign add_l   = la + lb;
        assign add_sat = 1'b0;
        assign sub_l   = diff[ELEM_BITS-1:0];
        assign sub_sat = 1'b0;
`endif

        // Pick the lane result for the latched operation
        always_comb begin
            res_l = add_l;
            sat_l = 1'b0;
            case (op_q)
                ADD: begin res_l = add_l; sat_l = add_sat; end
                SUB: begin res_l = sub_l; sat_l = sub_sat; end
                MIN: res_l = diff[ELEM_BITS] ? la : lb;
                MAX: res_l = diff[ELEM_BITS] ? lb : la;
                default: ;
            endcase
        end

        assign result[g*ELEM_BITS +: ELEM_BITS] = res_l;
        assign lane_sat[g] = sat_l;
    end

    // Run control: launch, issue all beats, wait for the final result to leave
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (length == '0) ? DONE : RUN;
            RUN:     if (last_pop) state_d = DRAIN;
            DRAIN:   if (!out_valid_q || c_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Launch parameters, beat counters, output register and sticky saturation
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= ADD;
            len_q       <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            issue_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                op_q        <= op_t'(op);
                len_q       <= length;
                a_cnt_q     <= '0;
                b_cnt_q     <= '0;
                issue_cnt_q <= '0;
                sat_q       <= 1'b0;
            end else begin
                if (a_push) a_cnt_q     <= a_cnt_q + LEN_BITS'(1);
                if (b_push) b_cnt_q     <= b_cnt_q + LEN_BITS'(1);
                if (pop)    issue_cnt_q <= issue_cnt_q + LEN_BITS'(1);
                if (pop && (|lane_sat)) sat_q <= 1'b1;
            end
            if (pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
            end else if (c_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
